// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared definitions for the systolic feed sequencer: FSM state encoding and datapath constants.
package systolic_feed_ctrl_pkg;

  localparam int unsigned ARRAY_N_DEF = 8;
  localparam int unsigned BRAM_DATA_W = 64;

  typedef enum logic [1:0] {
    FeedIdle  = 2'd0,
    FeedFetch = 2'd1,
    FeedDrain = 2'd2,
    FeedDone  = 2'd3
  } feed_state_e;

endpackage

// File: rtl/systolic_feed_ctrl.sv
// Streams a block of BRAM words into the systolic skew unit, then flushes the skew pipeline with
// ARRAY_N-1 zero words and pulses done_o.
module systolic_feed_ctrl
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LEN_W   = 11,
  parameter int unsigned ARRAY_N = ARRAY_N_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  num_words_i,
  input  logic              stall_i,
  output logic              bram_en_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic              skew_en_o,
  output logic              zero_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CNT_W = (ARRAY_N > 2) ? $clog2(ARRAY_N) : 1;

  feed_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              pending_q;
  logic [CNT_W-1:0]  drain_q;

  logic issue;
  logic consume;

  // pending_q means a word sits in the BRAM output register waiting for the skew unit.
  always_comb begin
    issue   = 1'b0;
    consume = 1'b0;
    if (state_q == FeedFetch) begin
      issue   = !stall_i && (remaining_q != '0);
      consume = pending_q && !stall_i;
    end
  end

  always_comb begin
    bram_en_o   = issue;
    bram_addr_o = ptr_q;
    skew_en_o   = consume || ((state_q == FeedDrain) && !stall_i);
    zero_o      = (state_q == FeedDrain);
    busy_o      = (state_q != FeedIdle);
    done_o      = (state_q == FeedDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FeedIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      pending_q   <= 1'b0;
      drain_q     <= '0;
    end else begin
      unique case (state_q)
        FeedIdle: begin
          if (start_i) begin
            if (num_words_i != '0) begin
              ptr_q       <= base_addr_i;
              remaining_q <= num_words_i;
              state_q     <= FeedFetch;
            end else begin
              state_q <= FeedDone;
            end
          end
        end
        FeedFetch: begin
          if (issue) begin
            ptr_q       <= ptr_q + ADDR_W'(1);
            remaining_q <= remaining_q - LEN_W'(1);
            pending_q   <= 1'b1;
          end else if (consume) begin
            pending_q <= 1'b0;
          end
          // Last buffered word leaves with nothing left to fetch.
          if (consume && (remaining_q == '0)) begin
            state_q <= FeedDrain;
            drain_q <= CNT_W'(ARRAY_N - 1);
          end
        end
        FeedDrain: begin
          if (!stall_i) begin
            if (drain_q == CNT_W'(1)) begin
              state_q <= FeedDone;
            end else begin
              drain_q <= drain_q - CNT_W'(1);
            end
          end
        end
        FeedDone: begin
          state_q <= FeedIdle;
        end
        default: begin
          state_q <= FeedIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomized bench for systolic_feed_ctrl: a BRAM model plus a progress-count reference that
// predicts each transfer's timing from its stall pattern alone.
module tb_systolic_feed_ctrl;

  localparam int AN  = 8;
  localparam int MEM = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] num_words;
  logic        stall;
  logic        bram_en;
  logic [9:0]  bram_addr;
  logic        skew_en;
  logic        zero;
  logic        busy;
  logic        done;

  logic [63:0] mem [MEM];
  logic [63:0] bram_dout;

  int n_cmp = 0;
  int n_err = 0;

  systolic_feed_ctrl #(
    .ADDR_W (10),
    .LEN_W  (11),
    .ARRAY_N(AN)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .base_addr_i(base_addr),
    .num_words_i(num_words),
    .stall_i    (stall),
    .bram_en_o  (bram_en),
    .bram_addr_o(bram_addr),
    .skew_en_o  (skew_en),
    .zero_o     (zero),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One transfer: cycle 0 is the cycle start is presented. Stalls in [slo, shi] are forced on
  // top of random ones. A stray start is presented at cycle extra_c while busy.
  task automatic run_xfer(input int base, input int n, input int stall_pct,
                          input int slo, input int shi, input int extra_c);
    bit st [4096];
    int u[$];
    int exp_done, exp_first_read, exp_first_skew, exp_first_zero;
    int n_rd = 0, n_data = 0, n_zero = 0, n_done = 0;
    int first_read = -1, first_skew = -1, first_zero = -1, done_cyc = -1;
    int addr_err = 0, data_err = 0, viol = 0, busy_err = 0;
    bit rd_v = 1'b0;
    logic [9:0] rd_a = '0;

    st[0] = 1'b0;
    for (int c = 1; c < 4096; c++) begin
      st[c] = ((c < 600) && (int'($urandom_range(0, 99)) < stall_pct)) || (c >= slo && c <= shi);
    end
    // Every unstalled busy cycle advances the transfer by exactly one step.
    for (int c = 1; c < 4096; c++) if (!st[c]) u.push_back(c);
    exp_done       = (n == 0) ? 1 : u[n + AN - 1] + 1;
    exp_first_read = (n == 0) ? -1 : u[0];
    exp_first_skew = (n == 0) ? -1 : u[1];
    exp_first_zero = (n == 0) ? -1 : u[n + 1];

    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 10'(base);
    num_words = 11'(n);
    stall     = st[0];
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (bram_en) begin
        if (stall) viol++;
        if (int'(bram_addr) != (base + n_rd) % MEM) addr_err++;
        if (n_rd == 0) first_read = c;
        n_rd++;
      end
      if (skew_en) begin
        if (stall) viol++;
        if (zero) begin
          if (n_zero == 0) first_zero = c;
          n_zero++;
        end else begin
          if (n_data == 0) first_skew = c;
          if (n_data >= n || bram_dout !== mem[(base + n_data) % MEM]) data_err++;
          n_data++;
        end
      end
      if (done) begin
        n_done++;
        done_cyc = c;
      end
      if (busy != (c >= 1 && c <= exp_done)) busy_err++;
      rd_v = bram_en;
      rd_a = bram_addr;
      if (c >= exp_done + 2) break;
      @(posedge clk);
      if (rd_v) bram_dout = mem[rd_a];
      #1;
      start = (c + 1 == extra_c) && (c + 1 < exp_done);
      if (start) begin
        base_addr = 10'($urandom_range(0, MEM - 1));
        num_words = 11'($urandom_range(1, 50));
      end
      stall = st[c + 1];
    end
    start = 1'b0;
    stall = 1'b0;

    check_eq("done_cycle", done_cyc, exp_done);
    check_eq("done_pulses", n_done, 1);
    check_eq("busy_window_errs", busy_err, 0);
    check_eq("reads", n_rd, n);
    check_eq("addr_errs", addr_err, 0);
    check_eq("words_consumed", n_data, n);
    check_eq("data_errs", data_err, 0);
    check_eq("zero_words", n_zero, (n == 0) ? 0 : AN - 1);
    check_eq("stall_violations", viol, 0);
    check_eq("first_read", first_read, exp_first_read);
    check_eq("first_skew", first_skew, exp_first_skew);
    check_eq("first_zero", first_zero, exp_first_zero);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < MEM; i++) mem[i] = {$urandom(), $urandom()};
    bram_dout = '0;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    stall     = 1'b0;
    #12;
    check_eq("rst_bram_en", bram_en, 0);
    check_eq("rst_bram_addr", bram_addr, 0);
    check_eq("rst_skew_en", skew_en, 0);
    check_eq("rst_zero", zero, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_xfer(0, 4, 0, 0, -1, -1);       // basic
    run_xfer(0, 3, 0, 2, 4, -1);        // stall cycles 2-4
    run_xfer(1022, 4, 0, 0, -1, -1);    // address wrap
    run_xfer(77, 0, 0, 0, -1, -1);      // zero length
    run_xfer(200, 6, 0, 0, -1, 2);      // stray start during fetch
    run_xfer(5, 1024, 0, 0, -1, -1);    // full memory

    // Reset mid-operation at cycle 3 of an 8-word run.
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 10'd100;
    num_words = 11'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("midop_busy_before_rst", busy, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_bram_en", bram_en, 0);
    check_eq("midrst_bram_addr", bram_addr, 0);
    check_eq("midrst_skew_en", skew_en, 0);
    check_eq("midrst_zero", zero, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy || done || bram_en || skew_en) bad++;
    end
    check_eq("no_resume_after_rst", bad, 0);
    run_xfer(500, 5, 0, 0, -1, -1);

    for (int k = 0; k < 20; k++) begin
      run_xfer(int'($urandom_range(0, MEM - 1)), int'($urandom_range(0, 40)),
               int'($urandom_range(0, 40)), 0, -1,
               (k % 3 == 0) ? int'($urandom_range(1, 6)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
